// File: rtl/cpu_axi_arbiter_if.sv
// rtl/cpu_axi_arbiter_if.sv - single-beat AXI3 master channel bundle between arbiter and crossbar
interface cpu_axi_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arsize, arvalid, rready,
        output awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rid, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  arid, araddr, arsize, arvalid, rready,
        input  awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rid, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/cpu_axi_arbiter.sv
// rtl/cpu_axi_arbiter.sv - shares one AXI3 master between CPU fetch and data ports (ARB_RR_EN selects round-robin grant)
module cpu_axi_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_stall,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic [31:0] data_rdata,
    output logic        data_stall,
    cpu_axi_arbiter_if.master axi
);

    typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

    state_t      state, nextState;
    logic        instDone, dataDone;
    logic        grantData;
    logic        awDone, wDone;
    logic [31:0] curAddr, curWdata;
    logic [2:0]  curSize;
    logic [3:0]  curStrb;
    logic        instCand, dataCand, pickInst, pickData;
    logic        instFin, dataFin;
    logic        arvalidC, rreadyC, awvalidC, wvalidC, breadyC;
`ifdef ARB_RR_EN
    logic        lastGrantData;
`endif

    // a completed port stays quiet until the pipeline advances
    assign inst_stall = inst_req & ~instDone;
    assign data_stall = data_req & ~dataDone;

    // pick the next requester among ports that still need service
    always_comb begin
        instCand = inst_req & ~instDone;
        dataCand = data_req & ~dataDone;
`ifdef ARB_RR_EN
        pickData = dataCand & (~instCand | ~lastGrantData);
`else
        pickData = dataCand;
`endif
        pickInst = instCand & ~pickData;
    end

    // next-state and channel handshake outputs
    always_comb begin
        nextState = state;
        arvalidC  = 1'b0;
        rreadyC   = 1'b0;
        awvalidC  = 1'b0;
        wvalidC   = 1'b0;
        breadyC   = 1'b0;
        instFin   = 1'b0;
        dataFin   = 1'b0;
        case (state)
            IDLE: begin
                if (pickData && data_wr) nextState = W;
                else if (pickData || pickInst) nextState = AR;
            end
            AR: begin
                arvalidC = 1'b1;
                if (axi.arready) nextState = R;
            end
            R: begin
                rreadyC = 1'b1;
                if (axi.rvalid) begin
                    nextState = IDLE;
                    instFin   = ~grantData;
                    dataFin   = grantData;
                end
            end
            W: begin
                awvalidC = ~awDone;
                wvalidC  = ~wDone;
                if ((awDone | axi.awready) && (wDone | axi.wready)) nextState = B;
            end
            B: begin
                breadyC = 1'b1;
                if (axi.bvalid) begin
                    nextState = IDLE;
                    dataFin   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // request latch, write-channel progress, read data capture and done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            instDone   <= 1'b0;
            dataDone   <= 1'b0;
            grantData  <= 1'b0;
            awDone     <= 1'b0;
            wDone      <= 1'b0;
            curAddr    <= '0;
            curWdata   <= '0;
            curSize    <= '0;
            curStrb    <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
`ifdef ARB_RR_EN
            lastGrantData <= 1'b1;
`endif
        end else begin
            // a completion coinciding with adv means its requester already left: drop it
            instDone <= (instDone | instFin) & ~adv;
            dataDone <= (dataDone | dataFin) & ~adv;
            if (state == IDLE && (pickInst || pickData)) begin
                grantData <= pickData;
                curAddr   <= pickData ? data_addr : inst_addr;
                curSize   <= pickData ? {1'b0, data_size} : 3'd2;
                curWdata  <= data_wdata;
                curStrb   <= data_wstrb;
                awDone    <= 1'b0;
                wDone     <= 1'b0;
`ifdef ARB_RR_EN
                lastGrantData <= pickData;
`endif
            end
            if (awvalidC && axi.awready) awDone <= 1'b1;
            if (wvalidC && axi.wready)   wDone  <= 1'b1;
            if (state == R && axi.rvalid) begin
                if (grantData) data_rdata <= axi.rdata;
                else           inst_rdata <= axi.rdata;
            end
        end
    end

    assign axi.arid    = grantData ? DATA_ID : INST_ID;
    assign axi.araddr  = curAddr;
    assign axi.arsize  = curSize;
    assign axi.arvalid = arvalidC;
    assign axi.rready  = rreadyC;
    assign axi.awid    = DATA_ID;
    assign axi.awaddr  = curAddr;
    assign axi.awsize  = curSize;
    assign axi.awvalid = awvalidC;
    assign axi.wdata   = curWdata;
    assign axi.wstrb   = curStrb;
    assign axi.wvalid  = wvalidC;
    assign axi.bready  = breadyC;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// tb/tb_cpu_axi_arbiter.sv - randomized bench for cpu_axi_arbiter with AXI slave and grant-order model
module tb_cpu_axi_arbiter;
    localparam logic [3:0]  INST_ID = 4'd0;
    localparam logic [3:0]  DATA_ID = 4'd1;
    localparam logic [31:0] MEMKEY  = 32'h83DD0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adv = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_rdata;
    logic        data_stall;

    cpu_axi_arbiter_if axi();

    cpu_axi_arbiter #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
        .clk(clk), .rst(rst), .adv(adv),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_rdata(data_rdata), .data_stall(data_stall),
        .axi(axi.master)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {wr, id, size, addr} per address handshake, {strb, data} per W handshake
    logic [39:0] txLog[$];
    logic [35:0] wLog[$];

    int arDly = 0, awDly = 0, wDly = 0, rDly = 0, bDly = 0;
    bit rndDly = 0;

    bit arHs, rHs, awHs, wHs, bHs, awGot, wGot, rPend, bPend, arvP, awvP, wvP;
    int arCnt, awCnt, wCnt, rWait, bWait;
    logic [31:0] rNext, arFirst, awFirst, sAraddr, sAwaddr, sWdata;
    logic [3:0]  sArid, sAwid, sWstrb;
    logic [2:0]  sArsize, sAwsize;

    // AXI slave: acts 1 time unit after each rising edge, readys delayed per channel
    initial begin
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rid = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                {arHs, rHs, awHs, wHs, bHs, awGot, wGot, rPend, bPend, arvP, awvP, wvP} = '0;
                arCnt = 0; awCnt = 0; wCnt = 0;
                axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
            end else begin
                if (arHs) begin
                    txLog.push_back({1'b0, sArid, sArsize, sAraddr});
                    check("ar_addr_stable", sAraddr, arFirst);
                    rPend = 1; rWait = rDly; rNext = sAraddr ^ MEMKEY;
                    if (rndDly) begin arDly = $urandom_range(0, 3); rDly = $urandom_range(0, 3); end
                end
                if (rHs) rPend = 0;
                if (awHs) begin
                    txLog.push_back({1'b1, sAwid, sAwsize, sAwaddr});
                    check("aw_addr_stable", sAwaddr, awFirst);
                    awGot = 1;
                    if (rndDly) awDly = $urandom_range(0, 3);
                end
                if (wHs) begin
                    wLog.push_back({sWstrb, sWdata});
                    wGot = 1;
                    if (rndDly) wDly = $urandom_range(0, 3);
                end
                if (awGot && wGot) begin
                    bPend = 1; bWait = bDly; awGot = 0; wGot = 0;
                    if (rndDly) bDly = $urandom_range(0, 3);
                end
                if (bHs) bPend = 0;
                if (arvP && !arHs) check("ar_hold", axi.arvalid, 1);
                if (awvP && !awHs) check("aw_hold", axi.awvalid, 1);
                if (wvP && !wHs)   check("w_hold", axi.wvalid, 1);

                if (axi.arvalid && arCnt == 0) arFirst = axi.araddr;
                if (axi.awvalid && awCnt == 0) awFirst = axi.awaddr;
                axi.arready = axi.arvalid && arCnt >= arDly;
                axi.awready = axi.awvalid && awCnt >= awDly;
                axi.wready  = axi.wvalid && wCnt >= wDly;
                arCnt = axi.arvalid ? arCnt + 1 : 0;
                awCnt = axi.awvalid ? awCnt + 1 : 0;
                wCnt  = axi.wvalid ? wCnt + 1 : 0;
                axi.rvalid = rPend && rWait == 0;
                axi.rdata  = rNext;
                if (rPend && rWait > 0) rWait--;
                axi.bvalid = bPend && bWait == 0;
                if (bPend && bWait > 0) bWait--;

                arvP = axi.arvalid; awvP = axi.awvalid; wvP = axi.wvalid;
                arHs = axi.arvalid && axi.arready;
                awHs = axi.awvalid && axi.awready;
                wHs  = axi.wvalid && axi.wready;
                rHs  = axi.rvalid && axi.rready;
                bHs  = axi.bvalid && axi.bready;
                sArid = axi.arid; sArsize = axi.arsize; sAraddr = axi.araddr;
                sAwid = axi.awid; sAwsize = axi.awsize; sAwaddr = axi.awaddr;
                sWdata = axi.wdata; sWstrb = axi.wstrb;
            end
        end
    end

    // reference: which port the arbiter granted most recently (1 = data)
    bit lastData = 1;

    // one pipeline step: present requests, wait for both stalls to clear, hold, check, advance
    task automatic runStep(input bit iReq, input logic [31:0] iAddr,
                           input bit dReq, input bit dWr, input logic [1:0] dSz,
                           input logic [31:0] dAddr, input logic [31:0] dWd, input logic [3:0] dSt,
                           input int hold, input int expLat, input string tag);
        logic [39:0] expTx[$];
        logic [39:0] iTx, dTx;
        bit dFirst;
        int cycles;
        iTx = {1'b0, INST_ID, 3'd2, iAddr};
        dTx = {dWr, DATA_ID, {1'b0, dSz}, dAddr};
`ifdef ARB_RR_EN
        dFirst = !lastData;
`else
        dFirst = 1;
`endif
        if (iReq && dReq) begin
            if (dFirst) begin expTx.push_back(dTx); expTx.push_back(iTx); lastData = 0; end
            else        begin expTx.push_back(iTx); expTx.push_back(dTx); lastData = 1; end
        end else if (dReq) begin
            expTx.push_back(dTx); lastData = 1;
        end else if (iReq) begin
            expTx.push_back(iTx); lastData = 0;
        end
        txLog.delete();
        wLog.delete();
        @(negedge clk);
        adv = 0;
        inst_req = iReq; inst_addr = iAddr;
        data_req = dReq; data_wr = dWr; data_size = dSz; data_addr = dAddr;
        data_wdata = dWd; data_wstrb = dSt;
        #1;
        cycles = 0;
        while ((inst_stall || data_stall) && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 400) check({tag, "_timeout"}, cycles, 0);
        if (expLat >= 0) check({tag, "_latency"}, cycles, expLat);
        repeat (hold) @(negedge clk);
        if (hold > 0) check({tag, "_stall_after_hold"}, {inst_stall, data_stall}, 2'b00);
        check({tag, "_n_txn"}, txLog.size(), expTx.size());
        for (int i = 0; i < expTx.size() && i < txLog.size(); i++)
            check({tag, "_txn"}, txLog[i], expTx[i]);
        if (dReq && dWr) begin
            check({tag, "_n_w"}, wLog.size(), 1);
            if (wLog.size() > 0) check({tag, "_w"}, wLog[0], {dSt, dWd});
        end
        if (iReq) check({tag, "_inst_rdata"}, inst_rdata, iAddr ^ MEMKEY);
        if (dReq && !dWr) check({tag, "_data_rdata"}, data_rdata, dAddr ^ MEMKEY);
        adv = 1;
        @(negedge clk);
        adv = 0; inst_req = 0; data_req = 0;
    endtask

    initial begin
        int n;
        logic [31:0] iA;
        bit iR, dR;
        // reset state
        inst_req = 1;
        repeat (3) @(negedge clk);
        check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);
        check("rst_stalls", {inst_stall, data_stall}, 2'b10);
        inst_req = 0;
        rst = 0;
        @(negedge clk);

        // zero-wait single read and write
        runStep(1, 32'hBFC00000, 0, 0, 2'd2, 0, 0, 0, 0, 3, "t1");
        check("t1_rdata_held", inst_rdata, 32'h3C1D0000);
        runStep(0, 0, 1, 1, 2'd2, 32'h80000010, 32'hDEADBEEF, 4'hF, 0, 3, "wr0");

        // write with staggered AW/W readys
        awDly = 1; wDly = 3;
        runStep(0, 0, 1, 1, 2'd1, 32'h80001004, 32'h12345678, 4'b0011, 2, 6, "t2");
        awDly = 0; wDly = 0;

        // both ports request, repeated: grant order from policy, no re-issue while held
        for (int k = 0; k < 3; k++) begin
            rDly = k;
            runStep(1, 32'hBFC00004 + 32'(k * 4), 1, 0, 2'd2, 32'h80000020 + 32'(k * 4),
                    0, 0, 5, -1, "both");
        end
        rDly = 0;

        // reset while waiting on R
        rDly = 30;
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC00100;
        n = 0;
        while (!axi.rready && n < 20) begin @(negedge clk); n++; end
        check("t5_in_r", axi.rready, 1);
        rst = 1;
        @(negedge clk);
        check("t5_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid}, 4'b0);
        check("t5_stalls", {inst_stall, data_stall}, 2'b10);
        check("t5_rdata", inst_rdata, 0);
        rDly = 0;
        lastData = 1;
        inst_req = 0;
        rst = 0;
        @(negedge clk);
        runStep(1, 32'hBFC00200, 0, 0, 2'd2, 0, 0, 0, 0, 3, "t5_after");

        // randomized steps with random slave delays
        rndDly = 1;
        for (int k = 0; k < 60; k++) begin
            iR = 1'($urandom_range(0, 1));
            dR = 1'($urandom_range(0, 1));
            if (!iR && !dR) iR = 1;
            iA = {$urandom} & 32'hFFFF_FFFC;
            runStep(iR, iA, dR, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    $urandom, $urandom, 4'($urandom), $urandom_range(0, 3), -1, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
